// File: rtl/uart_rx_sched.sv
// uart_rx_sched: receive byte FIFO behind an AHB-lite register view, scheduling one level irq (threshold/error/idle timeout).
// Latency: AHB response and read data registered one cycle after the address phase; irq one cycle after its cause.
// Backpressure: none toward the shifter (a full FIFO drops and flags overrun); idle timeout only with UART_RX_TIMEOUT_EN.
module uart_rx_sched #(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = $clog2(DEPTH) + 1,
    parameter int TIMEOUT_CYC = 19096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_err,
    input  logic        hsel_rx,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic        irq_uartRx
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d;
    logic [3:0]       thr_q, thr_d;
    logic             thr_ie_q, thr_ie_d, err_ie_q, err_ie_d;
    logic             wpend_q, wpend_d;
    logic [1:0]       waddr_q, waddr_d;
    logic [31:0]      hrdata_q, hrdata_d;
    logic             hready_q, hready_d;
    logic [1:0]       hresp_q, hresp_d;
    logic             irq_q, irq_d;

    logic        acc, rd_acc, wr_acc, empty, full, pop, push_ok, ovr_set, flush;
    logic        ctrl_wr, stat_wr;
    logic [1:0]  asel;
    logic [4:0]  thr_eff;
    logic [31:0] status_val, ctrl_val;
    logic        tout_flag, to_ie_flag;
    logic        unused_bits;

    assign unused_bits = ^{HADDR, HWDATA};

    assign acc     = hsel_rx && (HTRANS == 2'b10);
    assign rd_acc  = acc && !HWRITE;
    assign wr_acc  = acc && HWRITE;
    assign asel    = HADDR[3:2];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop     = rd_acc && (asel == 2'd0) && !empty;
    assign ctrl_wr = wpend_q && (waddr_q == 2'd2);
    assign stat_wr = wpend_q && (waddr_q == 2'd1);
    assign flush   = ctrl_wr && HWDATA[16];
    // A flush discards a same-cycle byte outright, so it is neither stored nor counted as overrun.
    assign push_ok = rx_byte_valid && !flush && (!full || pop);
    assign ovr_set = rx_byte_valid && !flush && full && !pop;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
    logic            to_arm_q, to_arm_d, tout_q, tout_d, to_ie_q, to_ie_d, tout_set;

    always_comb begin
        to_cnt_d   = to_cnt_q;
        to_arm_d   = to_arm_q;
        tout_set   = 1'b0;
        to_cnt_inc = to_cnt_q + TO_W'(1);
        if (flush || push_ok || pop || empty) begin
            to_cnt_d = '0;
            if (flush)        to_arm_d = 1'b0;
            else if (push_ok) to_arm_d = 1'b1;
        end else if (to_arm_q) begin
            // Fires once as the count reaches TIMEOUT_CYC-1; only a new push re-arms it.
            if (to_cnt_inc == TO_W'(TIMEOUT_CYC - 1)) begin
                tout_set = 1'b1;
                to_cnt_d = '0;
                to_arm_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_inc;
            end
        end
        tout_d  = tout_set | (tout_q & ~(stat_wr & HWDATA[10]));
        to_ie_d = ctrl_wr ? HWDATA[10] : to_ie_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_arm_q <= 1'b0;
            tout_q   <= 1'b0;
            to_ie_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_arm_q <= to_arm_d;
            tout_q   <= tout_d;
            to_ie_q  <= to_ie_d;
        end
    end

    assign tout_flag  = tout_q;
    assign to_ie_flag = to_ie_q;
`else
    assign tout_flag  = 1'b0;
    assign to_ie_flag = 1'b0;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = rx_byte;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        // A flag being set in this cycle wins over a W1C clear of it.
        ovr_d    = ovr_set | (ovr_q & ~(stat_wr & HWDATA[8]));
        ferr_d   = rx_err | (ferr_q & ~(stat_wr & HWDATA[9]));
        thr_d    = ctrl_wr ? HWDATA[3:0] : thr_q;
        thr_ie_d = ctrl_wr ? HWDATA[8] : thr_ie_q;
        err_ie_d = ctrl_wr ? HWDATA[9] : err_ie_q;
        wpend_d  = wr_acc && ((asel == 2'd1) || (asel == 2'd2));
        waddr_d  = asel;
    end

    always_comb begin
        status_val                = '0;
        status_val[CNT_W-1:0]     = count_q;
        status_val[8]             = ovr_q;
        status_val[9]             = ferr_q;
        status_val[10]            = tout_flag;
        ctrl_val                  = '0;
        ctrl_val[3:0]             = thr_q;
        ctrl_val[8]               = thr_ie_q;
        ctrl_val[9]               = err_ie_q;
        ctrl_val[10]              = to_ie_flag;

        hrdata_d = '0;
        if (rd_acc) begin
            case (asel)
                2'd0:    hrdata_d = empty ? 32'h0000_0100 : {24'h0, mem_q[rd_ptr_q]};
                2'd1:    hrdata_d = status_val;
                2'd2:    hrdata_d = ctrl_val;
                default: hrdata_d = '0;
            endcase
        end
        hready_d = !(wr_acc && (asel == 2'd0));
        hresp_d  = {1'b0, wr_acc && (asel == 2'd0)};
    end

    always_comb begin
        if (thr_q == 4'd0)                   thr_eff = 5'd1;
        else if ({1'b0, thr_q} > 5'(DEPTH))  thr_eff = 5'(DEPTH);
        else                                 thr_eff = {1'b0, thr_q};
        irq_d = (thr_ie_q && (5'(count_q) >= thr_eff))
             || (err_ie_q && (ovr_q || ferr_q))
             || (to_ie_flag && tout_flag);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            thr_q    <= 4'd1;
            thr_ie_q <= 1'b0;
            err_ie_q <= 1'b0;
            wpend_q  <= 1'b0;
            waddr_q  <= 2'd0;
            hrdata_q <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 2'd0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            thr_q    <= thr_d;
            thr_ie_q <= thr_ie_d;
            err_ie_q <= err_ie_d;
            wpend_q  <= wpend_d;
            waddr_q  <= waddr_d;
            hrdata_q <= hrdata_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            irq_q    <= irq_d;
        end
    end

    assign HRDATA     = hrdata_q;
    assign HREADY     = hready_q;
    assign HRESP      = hresp_q;
    assign irq_uartRx = irq_q;
endmodule

// File: tb/tb_uart_rx_sched.sv
// Bench for uart_rx_sched: directed register scenarios plus random traffic against a queue-based reference model.
module tb_uart_rx_sched;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int T     = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_byte_valid, rx_err, hsel_rx, HWRITE;
    logic [7:0]  rx_byte;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HREADY, irq_uartRx;

    always #5 clk = ~clk;

    uart_rx_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_err(rx_err),
        .hsel_rx(hsel_rx), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .irq_uartRx(irq_uartRx)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mq[$];
    bit          m_ovr, m_ferr, m_to, m_thr_ie, m_err_ie, m_to_ie, m_wpend, m_armed;
    int          m_thr;
    logic [1:0]  m_waddr;
    longint      now_cyc = 0;
    longint      deadline = -1;
    logic [31:0] exp_hrdata = '0;
    logic        exp_hready = 1'b1;
    logic [1:0]  exp_hresp = 2'd0;
    logic        exp_irq = 1'b0;
    bit          chk_en = 0;

    function automatic logic [31:0] m_status();
        logic [31:0] v;
        v = 32'(mq.size());
        v[8] = m_ovr; v[9] = m_ferr; v[10] = m_to;
        return v;
    endfunction

    function automatic logic [31:0] m_ctrl();
        logic [31:0] v;
        v = 32'(m_thr);
        v[8] = m_thr_ie; v[9] = m_err_ie; v[10] = m_to_ie;
        return v;
    endfunction

    function automatic bit m_irq();
        int te;
        te = (m_thr == 0) ? 1 : ((m_thr > DEPTH) ? DEPTH : m_thr);
        return (m_thr_ie && mq.size() >= te) || (m_err_ie && (m_ovr || m_ferr)) || (m_to_ie && m_to);
    endfunction

    always @(posedge clk) begin
        bit         acc, do_pop, do_push, flush, set_ovr, set_to, irq_pre, clr_o, clr_f, clr_t;
        logic [1:0] a;
        if (rst) begin
            mq.delete();
            {m_ovr, m_ferr, m_to, m_thr_ie, m_err_ie, m_to_ie, m_wpend, m_armed} = '0;
            m_thr = 1; m_waddr = 2'd0; deadline = -1;
            exp_hrdata = '0; exp_hready = 1'b1; exp_hresp = 2'd0; exp_irq = 1'b0;
        end else begin
            irq_pre = m_irq();
            acc = hsel_rx && (HTRANS == 2'b10);
            a = HADDR[3:2];
            do_pop = 0; do_push = 0; flush = 0; set_ovr = 0; set_to = 0;
            clr_o = 0; clr_f = 0; clr_t = 0;
            exp_hrdata = '0; exp_hready = 1'b1; exp_hresp = 2'd0;
            if (acc && !HWRITE) begin
                case (a)
                    2'd0: if (mq.size() > 0) begin exp_hrdata = {24'h0, mq[0]}; do_pop = 1; end
                          else exp_hrdata = 32'h100;
                    2'd1: exp_hrdata = m_status();
                    2'd2: exp_hrdata = m_ctrl();
                    default: exp_hrdata = '0;
                endcase
            end
            if (acc && HWRITE && a == 2'd0) begin exp_hready = 1'b0; exp_hresp = 2'd1; end
            if (m_wpend && m_waddr == 2'd2) begin
                m_thr = int'(HWDATA[3:0]); m_thr_ie = HWDATA[8]; m_err_ie = HWDATA[9];
`ifdef UART_RX_TIMEOUT_EN
                m_to_ie = HWDATA[10];
`endif
                flush = HWDATA[16];
            end
            if (m_wpend && m_waddr == 2'd1) begin
                clr_o = HWDATA[8]; clr_f = HWDATA[9]; clr_t = HWDATA[10];
            end
            if (flush) begin
                mq.delete(); deadline = -1; m_armed = 0;
            end else begin
                if (do_pop) begin
                    void'(mq.pop_front());
                    if (m_armed) deadline = now_cyc + T - 1;
                end
                if (rx_byte_valid) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(rx_byte); do_push = 1; m_armed = 1; deadline = now_cyc + T - 1;
                    end else set_ovr = 1;
                end
            end
`ifdef UART_RX_TIMEOUT_EN
            if (!flush && !do_pop && !do_push && mq.size() > 0 && m_armed && now_cyc == deadline) begin
                set_to = 1; m_armed = 0;
            end
`endif
            m_ovr  = set_ovr | (m_ovr & ~clr_o);
            m_ferr = rx_err  | (m_ferr & ~clr_f);
            m_to   = set_to  | (m_to & ~clr_t);
            m_wpend = acc && HWRITE && (a == 2'd1 || a == 2'd2);
            m_waddr = a;
            exp_irq = irq_pre;
        end
        now_cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("cyc_hrdata", HRDATA, exp_hrdata);
            check_eq("cyc_hready", 32'(HREADY), 32'(exp_hready));
            check_eq("cyc_hresp", 32'(HRESP), 32'(exp_hresp));
            check_eq("cyc_irq", 32'(irq_uartRx), 32'(exp_irq));
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0; rx_err = 1'b0; hsel_rx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_byte_valid = 1'b1; rx_byte = b;
        tick();
    endtask

    task automatic bus_read(input logic [3:0] addr, input bit with_push, input logic [7:0] b,
                            output logic [31:0] d);
        hsel_rx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0;
        HADDR = ($urandom() & 32'hFFFF_FFF3) | {28'h0, addr[3:2], 2'b00};
        rx_byte_valid = with_push; rx_byte = b;
        tick();
        d = HRDATA;
    endtask

    // pulse: 0 none, 1 push a byte, 2 rx_err, both during the data phase.
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input int pulse);
        hsel_rx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
        HADDR = ($urandom() & 32'hFFFF_FFF3) | {28'h0, addr[3:2], 2'b00};
        tick();
        HWDATA = data;
        rx_byte_valid = (pulse == 1); rx_byte = 8'($urandom()); rx_err = (pulse == 2);
        tick();
        HWDATA = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int k;
        rst = 1'b1; rx_byte_valid = 1'b0; rx_err = 1'b0; rx_byte = '0; hsel_rx = 1'b0;
        HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = '0;
        @(posedge clk); #1;
        chk_en = 1;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_hrdata", HRDATA, 32'h0);
        check_eq("rst_hready", 32'(HREADY), 32'h1);
        check_eq("rst_hresp", 32'(HRESP), 32'h0);
        check_eq("rst_irq", 32'(irq_uartRx), 32'h0);

        bus_read(4'h4, 0, 0, d); check_eq("rst_status", d, 32'h0);
        bus_read(4'h8, 0, 0, d); check_eq("rst_ctrl", d, 32'h1);
        bus_read(4'h0, 0, 0, d); check_eq("empty_data", d, 32'h100);
        bus_read(4'h4, 0, 0, d); check_eq("empty_cnt", d, 32'h0);

        push(8'hA5); push(8'h3C);
        bus_read(4'h4, 0, 0, d); check_eq("cnt2", d, 32'h2);
        bus_read(4'h0, 0, 0, d); check_eq("pop_a5", d, 32'hA5);
        bus_read(4'h4, 0, 0, d); check_eq("cnt1", d, 32'h1);
        bus_read(4'h0, 0, 0, d); check_eq("pop_3c", d, 32'h3C);
        bus_read(4'h4, 0, 0, d); check_eq("cnt0", d, 32'h0);

        bus_write(4'h8, 32'h104, 0);
        push(8'h01); push(8'h02); push(8'h03); tick();
        check_eq("thr_below", 32'(irq_uartRx), 32'h0);
        push(8'h04);
        check_eq("thr_same_edge", 32'(irq_uartRx), 32'h0);
        tick();
        check_eq("thr_reached", 32'(irq_uartRx), 32'h1);
        bus_read(4'h0, 0, 0, d); check_eq("thr_pop", d, 32'h01);
        tick();
        check_eq("thr_dropped", 32'(irq_uartRx), 32'h0);
        bus_write(4'h8, 32'h0001_0000, 0);
        bus_read(4'h4, 0, 0, d); check_eq("flush_cnt", d, 32'h0);
        bus_read(4'h8, 0, 0, d); check_eq("flush_self_clr", d, 32'h0);

        for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
        bus_read(4'h4, 0, 0, d); check_eq("overrun_status", d, 32'h108);
        bus_write(4'h4, 32'h100, 0);
        bus_read(4'h4, 0, 0, d); check_eq("w1c_ovr", d, 32'h008);
        bus_read(4'h0, 1, 8'h77, d); check_eq("full_pushpop", d, 32'h10);
        bus_read(4'h4, 0, 0, d); check_eq("full_pushpop_cnt", d, 32'h008);
        for (int i = 0; i < 8; i++) begin
            bus_read(4'h0, 0, 0, d);
            check_eq("drain", d, (i < 7) ? 32'(8'h11 + i) : 32'h77);
        end

        push(8'h66);
        hsel_rx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        tick();
        check_eq("dwr_hready", 32'(HREADY), 32'h0);
        check_eq("dwr_hresp", 32'(HRESP), 32'h1);
        HWDATA = 32'h55;
        tick();
        HWDATA = '0;
        check_eq("dwr_hready_after", 32'(HREADY), 32'h1);
        check_eq("dwr_hresp_after", 32'(HRESP), 32'h0);
        bus_read(4'h4, 0, 0, d); check_eq("dwr_cnt", d, 32'h1);
        bus_read(4'h0, 0, 0, d); check_eq("dwr_data", d, 32'h66);

        bus_write(4'h8, 32'h200, 0);
        rx_err = 1'b1; tick(); tick();
        check_eq("ferr_irq", 32'(irq_uartRx), 32'h1);
        bus_read(4'h4, 0, 0, d); check_eq("ferr_status", d, 32'h200);
        bus_write(4'h4, 32'h200, 2);
        bus_read(4'h4, 0, 0, d); check_eq("set_beats_clr", d, 32'h200);
        bus_write(4'h4, 32'h200, 0);
        bus_read(4'h4, 0, 0, d); check_eq("ferr_clr", d, 32'h0);

        bus_write(4'h8, 32'h408, 0);
        push(8'h99);
`ifdef UART_RX_TIMEOUT_EN
        for (k = 1; k <= 2 * T; k++) begin
            tick();
            if (irq_uartRx) break;
        end
        check_eq("to_irq_delay", 32'(k), 32'(T));
        bus_read(4'h4, 0, 0, d); check_eq("to_status", d, 32'h401);
        bus_write(4'h4, 32'h400, 0);
        repeat (T + 10) tick();
        bus_read(4'h4, 0, 0, d); check_eq("to_no_rearm", d, 32'h001);
`else
        repeat (T + 10) tick();
        check_eq("noto_irq", 32'(irq_uartRx), 32'h0);
        bus_read(4'h4, 0, 0, d); check_eq("noto_status", d, 32'h001);
        bus_read(4'h8, 0, 0, d); check_eq("noto_ctrl", d, 32'h008);
`endif
        bus_read(4'h0, 0, 0, d); check_eq("to_data", d, 32'h99);
        bus_write(4'h8, 32'h1, 0);

        for (int n = 0; n < 500; n++) begin
            int unsigned op;
            op = $urandom_range(0, 11);
            case (op)
                0, 1, 2: push(8'($urandom()));
                3: begin rx_err = 1'b1; tick(); end
                4, 5: bus_read(4'h0, $urandom_range(0, 1) == 1, 8'($urandom()), d);
                6: bus_read(4'h4, 0, 0, d);
                7: bus_read(4'h8, 0, 0, d);
                8: bus_write(4'h8, {15'h0, ($urandom_range(0, 7) == 0), 5'h0, 3'($urandom()), 4'h0,
                                    4'($urandom())}, $urandom_range(0, 2));
                9: bus_write(4'h4, {21'h0, 3'($urandom()), 8'h0}, $urandom_range(0, 2));
                10: begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus_write(($urandom_range(0, 1) == 1) ? 4'h0 : 4'hC, $urandom(), 0);
                        bus_read(4'hC, 0, 0, d);
                    end else begin
                        hsel_rx = 1'($urandom()); HWRITE = 1'($urandom()); HADDR = $urandom();
                        HTRANS = hsel_rx ? 2'($urandom_range(0, 3) == 2 ? 3 : $urandom_range(0, 1)) : 2'b10;
                        HWDATA = $urandom();
                        tick();
                        HWDATA = '0;
                    end
                end
                default: repeat (($urandom_range(0, 3) == 0) ? $urandom_range(T - 20, T + 30)
                                                             : $urandom_range(1, 5)) tick();
            endcase
        end
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_sched.md
# uart_rx_sched

Receive-side scheduler for the UART peripheral. It takes validated bytes from the UART receive shifter and buffers them in a DEPTH-entry FIFO. It exposes the buffered bytes and status/control registers to the core over AHB-lite, and schedules a single `irq_uartRx` from three sources: FIFO threshold, receive error and idle timeout. It sits between the receive shifter and the AHB peripheral mux.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `CNT_W`, $clog2(DEPTH)+1: occupancy counter width.
- `TIMEOUT_CYC`, 19096: idle clk cycles before a timeout (4 symbols at 434 clk/bit, 11 bits/symbol).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_byte_valid`  in  1  one-cycle pulse from shifter: symbol complete and correct.
- `rx_byte`  in  8  received data, valid with `rx_byte_valid`.
- `rx_err`  in  1  one-cycle pulse: symbol finished with bad start/stop/parity.
- `hsel_rx`, `HADDR`[31:0], `HWRITE`, `HTRANS`[1:0], `HWDATA`[31:0]  in  AHB-lite slave inputs; only `HADDR[3:2]` decoded.
- `HRDATA`  out  32  registered read data.
- `HREADY`  out  1  registered ready.
- `HRESP`  out  2  registered response (0 OKAY, 1 ERROR).
- `irq_uartRx`  out  1  registered interrupt, level.

## Operation
- Access is accepted only when `hsel_rx && HTRANS==NONSEQ`. Decode is on `HADDR[3:2]`; 3 is reserved: reads return 0, writes are ignored, response OKAY.
- DATA (0x0, RO): a read pops the head and returns {23'b0, 1'b0, byte}. A read when empty returns 0x100 and does not pop. A write gives an ERROR response and has no effect.
- STATUS (0x4): [CNT_W-1:0] occupancy; bit8 overrun, bit9 frame_err, bit10 timeout (all sticky). Writing 1 to bits 8-10 clears them (W1C).
- CTRL (0x8, RW), reset 0x0000_0001.
  - [3:0] threshold THR; 0 or >DEPTH is treated as 1 or DEPTH respectively.
  - bit8 thr_ie, bit9 err_ie, bit10 to_ie.
  - bit16 flush: self-clearing and reads 0. It empties the FIFO and zeroes the timeout counter; it does not touch the sticky flags.
- Push: `rx_byte_valid` writes `rx_byte` at the tail.
  - Full with no simultaneous pop: the byte is dropped, overrun is set, and the FIFO is unchanged.
  - Push and pop in the same cycle: both happen and the count is unchanged, including when full. Push with pop when empty is a plain push; the read returns 0x100.
- `rx_err` sets frame_err and pushes nothing.
- Flush and push in the same cycle: the flush wins and the byte is lost; overrun is not set.
- irq_next = (thr_ie && count>=THR) || (err_ie && (overrun||frame_err)) || (to_ie && timeout).
- The sticky-flag set wins over a W1C clear in the same cycle.

## Timing
- Reset: HRDATA=0, HREADY=1, HRESP=OKAY, irq_uartRx=0. FIFO is empty, all flags 0, CTRL=0x1, timeout counter 0.
- AHB response is registered, one cycle after the address phase. HWDATA is sampled in the data phase (cycle after the address phase); the write takes effect at the end of that cycle.
- Pop pointer and count update at the end of the address-phase cycle. HRDATA holds the popped byte during the following cycle and is 0 otherwise.
- DATA write: in the response cycle HREADY=0 and HRESP=ERROR for one cycle, then HREADY=1 and HRESP=OKAY.
- Occupancy counts a push on the same edge it is accepted. irq_uartRx reflects irq_next one cycle later.
- Timeout counter:
  - Increments each cycle while count!=0.
  - Clears on any push, pop, flush, or when count==0.
  - At TIMEOUT_CYC-1 it sets timeout and holds at 0; it does not re-arm until the next push.

## Configuration
- `UART_RX_TIMEOUT_EN` defined: the timeout counter, timeout flag and to_ie are implemented as described.
- Not defined: no counter is built. STATUS bit10 and CTRL bit10 read 0 and ignore writes, and the timeout term is absent from irq_next.

## Test plan
- Reset, then read STATUS -> 0x0; read CTRL -> 0x1; read DATA -> 0x100, and count stays 0.
- Push 0xA5, 0x3C; read DATA twice -> 0xA5 then 0x3C, with count 2->1->0.
- CTRL=0x104 (THR=4, thr_ie); push 3 bytes -> irq stays 0; 4th push -> irq=1 one cycle later; one pop -> irq=0.
- DEPTH=8: push 9 bytes -> 9th dropped, STATUS=0x108; a push and pop in the same cycle while full -> count stays 8, no new overrun; write STATUS 0x100 -> overrun cleared.
- DATA write 0x55 -> one response cycle with HREADY=0, HRESP=ERROR, FIFO unchanged; `rx_err` with err_ie set -> frame_err=1 and irq=1.
- With `UART_RX_TIMEOUT_EN`, CTRL=0x408 and one byte pushed -> timeout=1 and irq=1 exactly TIMEOUT_CYC cycles after the push. Without the macro -> STATUS bit10 stays 0.
